// File: rtl/shader_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shader_sequencer
// Purpose  : Frame controller for the pixel_shader array: broadcast voxels,
//            then palette entries, then scan the grid onto a pixel stream.
// Revision : 1.0
// ============================================================================
module shader_sequencer #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 8,
  parameter int COORD_BITS      = 8,
  parameter int PALETTE_BITS    = 8,
  parameter int PALETTE_ENTRIES = 16,
  parameter int PIXEL_BITS      = 8,
  parameter int VOXEL_ADDR_BITS = 10
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [VOXEL_ADDR_BITS:0]             num_voxels,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [VOXEL_ADDR_BITS-1:0]           voxel_addr,
  output logic                                 voxel_rd,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] voxel_rdata,
  output logic [PALETTE_BITS-1:0]              palette_addr,
  output logic                                 palette_rd,
  input  logic [PIXEL_BITS-1:0]                palette_rdata,
  output logic                                 do_rasterize,
  output logic                                 do_shade,
  output logic [COORD_BITS-1:0]                voxel_x,
  output logic [COORD_BITS-1:0]                voxel_y,
  output logic [COORD_BITS-1:0]                voxel_z,
  output logic [PALETTE_BITS-1:0]              voxel_id,
  output logic [PIXEL_BITS-1:0]                palette_entry,
  input  logic                                 rasterizing_done,
  input  logic                                 shading_done,
  output logic [ROW_BITS-1:0]                  row,
  output logic [COL_BITS-1:0]                  col,
  input  logic [PIXEL_BITS-1:0]                pixel,
  output logic                                 px_valid,
  input  logic                                 px_ready,
  output logic [PIXEL_BITS-1:0]                px_data,
  output logic [ROW_BITS-1:0]                  px_row,
  output logic [COL_BITS-1:0]                  px_col,
  output logic                                 px_last
);

  localparam logic [ROW_BITS-1:0]   c_ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0]   c_COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [PALETTE_BITS:0] c_PAL_LAST = (PALETTE_BITS+1)'(PALETTE_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_V_FETCH = 4'd1,
    S_V_LATCH = 4'd2,
    S_V_PULSE = 4'd3,
    S_V_WAIT  = 4'd4,
    S_P_FETCH = 4'd5,
    S_P_LATCH = 4'd6,
    S_P_PULSE = 4'd7,
    S_P_WAIT  = 4'd8,
    S_R_SEL   = 4'd9,
    S_R_OUT   = 4'd10,
    S_DONE    = 4'd11
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [VOXEL_ADDR_BITS:0]    r_nvox;
  logic [VOXEL_ADDR_BITS:0]    r_vidx;
  logic [VOXEL_ADDR_BITS:0]    w_vidx_inc;
  logic [PALETTE_BITS:0]       r_pidx;
  logic [ROW_BITS-1:0]         r_row;
  logic [COL_BITS-1:0]         r_col;
  logic [COORD_BITS-1:0]       r_voxel_x;
  logic [COORD_BITS-1:0]       r_voxel_y;
  logic [COORD_BITS-1:0]       r_voxel_z;
  logic [PALETTE_BITS-1:0]     r_voxel_id;
  logic [PIXEL_BITS-1:0]       r_palette_entry;
  logic [PIXEL_BITS-1:0]       r_px_data;
  logic [ROW_BITS-1:0]         r_px_row;
  logic [COL_BITS-1:0]         r_px_col;
  logic                        r_last;
  logic                        w_scan;

  assign w_vidx_inc = r_vidx + 1'b1;
  assign w_scan     = (r_state == S_R_SEL) || (r_state == S_R_OUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (num_voxels == '0) ? S_P_FETCH : S_V_FETCH;
      S_V_FETCH: w_next = S_V_LATCH;
      S_V_LATCH: w_next = S_V_PULSE;
      S_V_PULSE: w_next = S_V_WAIT;
      S_V_WAIT:  if (rasterizing_done) w_next = (w_vidx_inc < r_nvox) ? S_V_FETCH : S_P_FETCH;
      S_P_FETCH: w_next = S_P_LATCH;
      S_P_LATCH: w_next = S_P_PULSE;
      S_P_PULSE: w_next = S_P_WAIT;
      S_P_WAIT:  if (shading_done) w_next = (r_pidx == c_PAL_LAST) ? S_R_SEL : S_P_FETCH;
      S_R_SEL:   w_next = S_R_OUT;
      S_R_OUT:   if (px_ready) w_next = r_last ? S_DONE : S_R_SEL;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nvox          <= '0;
      r_vidx          <= '0;
      r_pidx          <= '0;
      r_row           <= '0;
      r_col           <= '0;
      r_voxel_x       <= '0;
      r_voxel_y       <= '0;
      r_voxel_z       <= '0;
      r_voxel_id      <= '0;
      r_palette_entry <= '0;
      r_px_data       <= '0;
      r_px_row        <= '0;
      r_px_col        <= '0;
      r_last          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_nvox <= num_voxels;
          r_vidx <= '0;
          r_pidx <= '0;
          r_row  <= '0;
          r_col  <= '0;
        end
        S_V_LATCH: {r_voxel_id, r_voxel_z, r_voxel_y, r_voxel_x} <= voxel_rdata;
        S_V_WAIT:  if (rasterizing_done) r_vidx <= w_vidx_inc;
        S_P_LATCH: begin
          r_palette_entry <= palette_rdata;
          r_voxel_id      <= r_pidx[PALETTE_BITS-1:0];
        end
        S_P_WAIT:  if (shading_done) r_pidx <= r_pidx + 1'b1;
        S_R_SEL: begin
          r_px_data <= pixel;
          r_px_row  <= r_row;
          r_px_col  <= r_col;
          r_last    <= (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
        end
        // Grid position advances only on a completed handshake
        S_R_OUT: if (px_ready && !r_last) begin
          if (r_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign frame_done    = (r_state == S_DONE);
  assign voxel_rd      = (r_state == S_V_FETCH);
  assign voxel_addr    = r_vidx[VOXEL_ADDR_BITS-1:0];
  assign palette_rd    = (r_state == S_P_FETCH);
  assign palette_addr  = r_pidx[PALETTE_BITS-1:0];
  assign do_rasterize  = (r_state == S_V_PULSE);
  assign do_shade      = (r_state == S_P_PULSE);
  assign voxel_x       = r_voxel_x;
  assign voxel_y       = r_voxel_y;
  assign voxel_z       = r_voxel_z;
  assign voxel_id      = r_voxel_id;
  assign palette_entry = r_palette_entry;
  // All-ones select keeps every shader off the shared pixel bus
  assign row           = w_scan ? r_row : '1;
  assign col           = w_scan ? r_col : '1;
  assign px_valid      = (r_state == S_R_OUT);
  assign px_data       = r_px_data;
  assign px_row        = r_px_row;
  assign px_col        = r_px_col;
  assign px_last       = r_last && (r_state == S_R_OUT);

endmodule
`default_nettype wire

// File: tb/tb_shader_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shader_sequencer
// Purpose  : Directed self-checking bench for shader_sequencer on a 2x2 grid.
// Revision : 1.0
// ============================================================================
module tb_shader_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] num_voxels = '0;
  logic        busy, frame_done, voxel_rd, palette_rd, do_rasterize, do_shade;
  logic [9:0]  voxel_addr;
  logic [31:0] voxel_rdata = '0;
  logic [7:0]  palette_addr, palette_rdata = '0;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id, palette_entry;
  logic        rasterizing_done = 1'b1;
  logic        shading_done = 1'b1;
  logic [7:0]  row, col, pixel, px_data, px_row, px_col;
  logic        px_valid, px_last;
  logic        px_ready = 1'b1;

  shader_sequencer #(
    .ROWS(2), .COLS(2), .ROW_BITS(8), .COL_BITS(8), .COORD_BITS(8),
    .PALETTE_BITS(8), .PALETTE_ENTRIES(4), .PIXEL_BITS(8), .VOXEL_ADDR_BITS(10)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_voxels(num_voxels),
    .busy(busy), .frame_done(frame_done), .voxel_addr(voxel_addr),
    .voxel_rd(voxel_rd), .voxel_rdata(voxel_rdata), .palette_addr(palette_addr),
    .palette_rd(palette_rd), .palette_rdata(palette_rdata),
    .do_rasterize(do_rasterize), .do_shade(do_shade), .voxel_x(voxel_x),
    .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
    .palette_entry(palette_entry), .rasterizing_done(rasterizing_done),
    .shading_done(shading_done), .row(row), .col(col), .pixel(pixel),
    .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
    .px_row(px_row), .px_col(px_col), .px_last(px_last)
  );

  always #5 clock = ~clock;

  // Voxel/palette RAMs with one-cycle read latency, plus shader-array stubs
  logic [31:0] vram [0:7];
  logic [7:0]  pram [0:3];
  logic [7:0]  grid_color = 8'h00;
  int          rcnt = 0;
  int          scnt = 0;

  always @(posedge clock) begin
    if (voxel_rd)   voxel_rdata   <= vram[voxel_addr[2:0]];
    if (palette_rd) palette_rdata <= pram[palette_addr[1:0]];
    if (do_rasterize) begin
      rcnt <= 4; rasterizing_done <= 1'b0;
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) rasterizing_done <= 1'b1;
    end
    if (do_shade) begin
      scnt <= 2; shading_done <= 1'b0;
      if (voxel_id == 8'd1) grid_color <= palette_entry;
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) shading_done <= 1'b1;
    end
  end

  assign pixel = (row < 8'd2 && col < 8'd2) ? grid_color : 8'h00;

  // Event recorders
  int          rast_n = 0, shade_n = 0, beats = 0, fd_n = 0, stab_err = 0;
  logic [7:0]  rast_id [0:63];
  logic [23:0] rast_zyx [0:63];
  logic [7:0]  sh_id [0:63];
  logic [7:0]  sh_ent [0:63];
  logic [7:0]  sh_x [0:63];
  logic [7:0]  b_data [0:63];
  logic [7:0]  b_row [0:63];
  logic [7:0]  b_col [0:63];
  logic        b_last [0:63];
  logic [31:0] snap = '0;
  logic        watch = 1'b0;

  always @(negedge clock) begin
    if (do_rasterize) begin
      rast_id[rast_n % 64]  <= voxel_id;
      rast_zyx[rast_n % 64] <= {voxel_z, voxel_y, voxel_x};
      rast_n <= rast_n + 1;
      snap   <= {voxel_id, voxel_z, voxel_y, voxel_x};
      watch  <= 1'b1;
    end else if (watch) begin
      if ({voxel_id, voxel_z, voxel_y, voxel_x} !== snap) stab_err <= stab_err + 1;
      if (rasterizing_done || reset) watch <= 1'b0;
    end
    if (do_shade) begin
      sh_id[shade_n % 64]  <= voxel_id;
      sh_ent[shade_n % 64] <= palette_entry;
      sh_x[shade_n % 64]   <= voxel_x;
      shade_n <= shade_n + 1;
    end
    if (px_valid && px_ready) begin
      b_data[beats % 64] <= px_data;
      b_row[beats % 64]  <= px_row;
      b_col[beats % 64]  <= px_col;
      b_last[beats % 64] <= px_last;
      beats <= beats + 1;
    end
    if (frame_done) fd_n <= fd_n + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic start_frame(input logic [10:0] n);
    @(negedge clock);
    num_voxels = n;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    int i = 0;
    while (!frame_done && i < 3000) begin
      @(negedge clock);
      i++;
    end
    ok = frame_done;
    @(negedge clock);
  endtask

  task automatic test_reset();
    int i = 0;
    int fd0;
    repeat (3) @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL por_busy got=%0h exp=0", busy); end
    tests++; if ({row, col} !== 16'hFFFF) begin fails++; $display("FAIL por_rowcol got=%0h exp=ffff", {row, col}); end
    reset = 1'b0;
    start_frame(11'd2);
    while (!do_rasterize && i < 50) begin @(negedge clock); i++; end
    tests++; if (do_rasterize !== 1'b1) begin fails++; $display("FAIL rst_reach_pulse got=%0h exp=1", do_rasterize); end
    repeat (2) @(negedge clock);
    fd0 = fd_n;
    #2 reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    tests++; if ({row, col} !== 16'hFFFF) begin fails++; $display("FAIL rst_rowcol got=%0h exp=ffff", {row, col}); end
    tests++; if ({voxel_id, voxel_z, voxel_y, voxel_x} !== 32'h0) begin fails++; $display("FAIL rst_voxel got=%0h exp=0", {voxel_id, voxel_z, voxel_y, voxel_x}); end
    tests++; if ({voxel_rd, palette_rd, do_rasterize, do_shade, px_valid, px_last, frame_done} !== 7'h0) begin
      fails++; $display("FAIL rst_strobes got=%0h exp=0", {voxel_rd, palette_rd, do_rasterize, do_shade, px_valid, px_last, frame_done}); end
    tests++; if ({voxel_addr, palette_addr, palette_entry, px_data} !== 34'h0) begin
      fails++; $display("FAIL rst_regs got=%0h exp=0", {voxel_addr, palette_addr, palette_entry, px_data}); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    tests++; if (fd_n - fd0 !== 0) begin fails++; $display("FAIL rst_no_frame_done got=%0d exp=0", fd_n - fd0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle_after got=%0h exp=0", busy); end
  endtask

  task automatic test_voxels();
    int r0 = rast_n, s0 = shade_n, b0 = beats, f0 = fd_n, e0 = stab_err;
    bit ok;
    start_frame(11'd2);
    tests++; if ({voxel_rd, voxel_addr} !== {1'b1, 10'd0}) begin fails++; $display("FAIL v_fetch got=%0h exp=400", {voxel_rd, voxel_addr}); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL v_busy got=%0h exp=1", busy); end
    repeat (2) @(negedge clock);
    tests++; if (do_rasterize !== 1'b1) begin fails++; $display("FAIL v_first_pulse_latency got=%0h exp=1", do_rasterize); end
    wait_frame(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL v_frame_timeout got=%0h exp=1", ok); end
    tests++; if (rast_n - r0 !== 2) begin fails++; $display("FAIL v_pulse_count got=%0d exp=2", rast_n - r0); end
    tests++; if (rast_id[r0 % 64] !== 8'd3) begin fails++; $display("FAIL v_id0 got=%0d exp=3", rast_id[r0 % 64]); end
    tests++; if (rast_id[(r0 + 1) % 64] !== 8'd5) begin fails++; $display("FAIL v_id1 got=%0d exp=5", rast_id[(r0 + 1) % 64]); end
    tests++; if (rast_zyx[r0 % 64] !== 24'h010200) begin fails++; $display("FAIL v_zyx0 got=%0h exp=10200", rast_zyx[r0 % 64]); end
    tests++; if (rast_zyx[(r0 + 1) % 64] !== 24'h040607) begin fails++; $display("FAIL v_zyx1 got=%0h exp=40607", rast_zyx[(r0 + 1) % 64]); end
    tests++; if (stab_err - e0 !== 0) begin fails++; $display("FAIL v_stable got=%0d exp=0", stab_err - e0); end
    tests++; if (shade_n - s0 !== 4) begin fails++; $display("FAIL v_shade_count got=%0d exp=4", shade_n - s0); end
    tests++; if (beats - b0 !== 4) begin fails++; $display("FAIL v_beats got=%0d exp=4", beats - b0); end
    tests++; if (fd_n - f0 !== 1) begin fails++; $display("FAIL v_frame_done got=%0d exp=1", fd_n - f0); end
  endtask

  task automatic test_palette_only();
    int r0 = rast_n, s0 = shade_n;
    bit ok;
    start_frame(11'd0);
    tests++; if ({voxel_rd, palette_rd} !== 2'b01) begin fails++; $display("FAIL p_skip_voxels got=%0h exp=1", {voxel_rd, palette_rd}); end
    wait_frame(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL p_frame_timeout got=%0h exp=1", ok); end
    tests++; if (rast_n - r0 !== 0) begin fails++; $display("FAIL p_no_raster got=%0d exp=0", rast_n - r0); end
    tests++; if (shade_n - s0 !== 4) begin fails++; $display("FAIL p_shade_count got=%0d exp=4", shade_n - s0); end
    for (int k = 0; k < 4; k++) begin
      tests++; if (sh_id[(s0 + k) % 64] !== 8'(k)) begin fails++; $display("FAIL p_id%0d got=%0d exp=%0d", k, sh_id[(s0 + k) % 64], k); end
      tests++; if (sh_ent[(s0 + k) % 64] !== pram[k]) begin fails++; $display("FAIL p_entry%0d got=%0h exp=%0h", k, sh_ent[(s0 + k) % 64], pram[k]); end
    end
    tests++; if (sh_x[s0 % 64] !== 8'd7) begin fails++; $display("FAIL p_x_kept got=%0d exp=7", sh_x[s0 % 64]); end
  endtask

  task automatic test_stream_backpressure();
    int b0 = beats, f0 = fd_n, i = 0;
    bit ok;
    vram[0] = {8'd1, 8'd0, 8'd0, 8'd0};
    px_ready = 1'b1;
    start_frame(11'd1);
    while (beats < b0 + 1 && i < 500) begin @(negedge clock); i++; end
    tests++; if (beats - b0 !== 1) begin fails++; $display("FAIL s_first_beat got=%0d exp=1", beats - b0); end
    px_ready = 1'b0;
    @(negedge clock);
    repeat (5) begin
      @(negedge clock);
      tests++; if ({px_valid, px_data, px_row, px_col} !== {1'b1, 8'hAB, 8'd0, 8'd1}) begin
        fails++; $display("FAIL s_hold got=%0h exp=%0h", {px_valid, px_data, px_row, px_col}, {1'b1, 8'hAB, 8'd0, 8'd1}); end
    end
    tests++; if (beats - b0 !== 1) begin fails++; $display("FAIL s_no_beat_when_stalled got=%0d exp=1", beats - b0); end
    px_ready = 1'b1;
    wait_frame(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL s_frame_timeout got=%0h exp=1", ok); end
    tests++; if (beats - b0 !== 4) begin fails++; $display("FAIL s_beats got=%0d exp=4", beats - b0); end
    for (int k = 0; k < 4; k++) begin
      tests++; if ({b_data[(b0 + k) % 64], b_row[(b0 + k) % 64], b_col[(b0 + k) % 64], b_last[(b0 + k) % 64]}
                   !== {8'hAB, 8'(k / 2), 8'(k % 2), (k == 3)}) begin
        fails++; $display("FAIL s_beat%0d got=%0h exp=%0h", k,
          {b_data[(b0 + k) % 64], b_row[(b0 + k) % 64], b_col[(b0 + k) % 64], b_last[(b0 + k) % 64]},
          {8'hAB, 8'(k / 2), 8'(k % 2), (k == 3)}); end
    end
    tests++; if (fd_n - f0 !== 1) begin fails++; $display("FAIL s_frame_done got=%0d exp=1", fd_n - f0); end
  endtask

  task automatic test_start_while_busy();
    int r0 = rast_n, f0 = fd_n, b0 = beats;
    bit ok;
    start_frame(11'd1);
    repeat (2) @(negedge clock);
    num_voxels = 11'd3;
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    wait_frame(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b_frame_timeout got=%0h exp=1", ok); end
    tests++; if (rast_n - r0 !== 1) begin fails++; $display("FAIL b_pulses got=%0d exp=1", rast_n - r0); end
    tests++; if (fd_n - f0 !== 1) begin fails++; $display("FAIL b_frame_done got=%0d exp=1", fd_n - f0); end
    tests++; if (beats - b0 !== 4) begin fails++; $display("FAIL b_beats got=%0d exp=4", beats - b0); end
    repeat (3) @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b_idle got=%0h exp=0", busy); end
  endtask

  initial begin
    vram[0] = {8'd3, 8'd1, 8'd2, 8'd0};
    vram[1] = {8'd5, 8'd4, 8'd6, 8'd7};
    for (int k = 2; k < 8; k++) vram[k] = '0;
    pram[0] = 8'h10; pram[1] = 8'hAB; pram[2] = 8'h30; pram[3] = 8'h40;
    test_reset();
    test_voxels();
    test_palette_only();
    test_stream_backpressure();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
